param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 113 +++++++++++
 tb/tb_param_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parameterised first-word fall-through FIFO.
// It has registered full/empty/count/head-data outputs and sticky overflow/underflow flags.
module param_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [W-1:0]             d_in,
   input  logic                     wr_en,
   output logic                     full,
   input  logic                     rd_en,
   output logic [W-1:0]             d_out,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     udf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic [W-1:0]  d_out_q, d_out_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic          wr_ok;
   logic          rd_ok;
   logic [CW-1:0] kept;

   // Accept/reject decisions, pointer and count update, and the next head-of-queue value.
   always_comb begin
      wr_ok   = wr_en && !full_q;
      rd_ok   = rd_en && !empty_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      d_out_d = '0;
      ovf_d   = ovf_q | (wr_en & full_q);
      udf_d   = udf_q | (rd_en & empty_q);

      if (wr_ok) begin
         wp_d = wp_q + AW'(1);
      end
      if (rd_ok) begin
         rp_d = rp_q + AW'(1);
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);

      // Entries that survive this edge's read. If none survive, the new head is the word written this edge.
      kept = count_q - CW'(rd_ok);
      if (empty_d) begin
         d_out_d = '0;
      end else if (kept == '0) begin
         d_out_d = d_in;
      end else begin
         d_out_d = mem_q[rp_d];
      end
   end

   // Control and status registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         d_out_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         d_out_q <= d_out_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array; contents are never reset, only made unreachable by clearing the pointers.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wp_q] <= d_in;
      end
   end

   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;
   assign d_out = d_out_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed and random checks of param_fifo against a queue-based reference model.
module tb_param_fifo;

   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk    = 1'b0;
   logic          resetn = 1'b1;
   logic [W-1:0]  d_in   = '0;
   logic          wr_en  = 1'b0;
   logic          rd_en  = 1'b0;
   logic          full;
   logic [W-1:0]  d_out;
   logic          empty;
   logic [CW-1:0] count;
   logic          ovf;
   logic          udf;

   logic [W-1:0]  mq [$];
   bit            m_ovf;
   bit            m_udf;
   int            n_assert;
   int            n_fail;

   param_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .d_in   (d_in),
      .wr_en  (wr_en),
      .full   (full),
      .rd_en  (rd_en),
      .d_out  (d_out),
      .empty  (empty),
      .count  (count),
      .ovf    (ovf),
      .udf    (udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      int unsigned sz;
      logic [W-1:0] head;
      sz   = mq.size();
      head = (sz != 0) ? mq[0] : '0;
      chk({ctx, "/count"}, 32'(count), sz);
      chk({ctx, "/full"},  32'(full),  32'(sz == DEPTH));
      chk({ctx, "/empty"}, 32'(empty), 32'(sz == 0));
      chk({ctx, "/d_out"}, 32'(d_out), 32'(head));
      chk({ctx, "/ovf"},   32'(ovf),   32'(m_ovf));
      chk({ctx, "/udf"},   32'(udf),   32'(m_udf));
   endtask

   // Drive one cycle of requests, apply the queue rules at the edge, then compare.
   task automatic step(input string ctx, input logic wr, input logic rd, input logic [W-1:0] din);
      bit was_full, was_empty;
      @(negedge clk);
      wr_en = wr;
      rd_en = rd;
      d_in  = din;
      @(posedge clk);
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      if (rd && !was_empty) void'(mq.pop_front());
      if (wr && !was_full)  mq.push_back(din);
      #1;
      check_all(ctx);
   endtask

   // Asynchronous reset asserted mid-cycle, held across an edge with requests, released at a falling edge.
   task automatic do_reset(input string ctx);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #1;
      check_all({ctx, "_async"});
      wr_en = 1'b1;
      rd_en = 1'b1;
      d_in  = 8'hFF;
      @(posedge clk);
      #1;
      check_all({ctx, "_held"});
      @(negedge clk);
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      resetn = 1'b1;
   endtask

   initial begin
      logic [W-1:0] exp_seq [4];
      n_assert = 0;
      n_fail   = 0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;

      #1 resetn = 1'b0;
      #2 check_all("por");
      @(negedge clk);
      resetn = 1'b1;

      // Reset with two entries stored
      step("pre_rst", 1'b1, 1'b0, 8'h11);
      step("pre_rst", 1'b1, 1'b0, 8'h22);
      chk("pre_rst_count", 32'(count), 32'd2);
      do_reset("rst2");
      chk("rst2_dout_zero", 32'(d_out), 32'h0);
      step("post_rst_idle", 1'b0, 1'b0, 8'h00);

      // Fill, overflow, drain
      step("fill", 1'b1, 1'b0, 8'h11);
      chk("fill_first_head", 32'(d_out), 32'h11);
      step("fill", 1'b1, 1'b0, 8'h22);
      step("fill", 1'b1, 1'b0, 8'h33);
      step("fill", 1'b1, 1'b0, 8'h44);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count4", 32'(count), 32'd4);
      step("ovf", 1'b1, 1'b0, 8'h55);
      chk("ovf_flag", 32'(ovf), 32'd1);
      chk("ovf_count4", 32'(count), 32'd4);
      exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 32'(d_out), 32'(exp_seq[i]));
         step("drain", 1'b0, 1'b1, 8'h00);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Underflow, then simultaneous access while empty
      step("udf", 1'b0, 1'b1, 8'h00);
      chk("udf_flag", 32'(udf), 32'd1);
      chk("udf_count0", 32'(count), 32'd0);
      step("empty_both", 1'b1, 1'b1, 8'hA5);
      chk("empty_both_count", 32'(count), 32'd1);
      chk("empty_both_dout", 32'(d_out), 32'hA5);

      // Simultaneous access while full
      do_reset("rst3");
      for (int i = 0; i < 4; i++) step("fill2", 1'b1, 1'b0, 8'(8'h60 + i));
      step("full_both", 1'b1, 1'b1, 8'h77);
      chk("full_both_count", 32'(count), 32'd3);
      chk("full_both_dout", 32'(d_out), 32'h61);

      // Pointer wrap at a steady count of two
      do_reset("rst4");
      step("wrap_pre", 1'b1, 1'b0, 8'h01);
      step("wrap_pre", 1'b1, 1'b0, 8'h02);
      for (int i = 3; i <= 12; i++) begin
         step("wrap", 1'b1, 1'b1, 8'(i));
         chk("wrap_count2", 32'(count), 32'd2);
         chk("wrap_head", 32'(d_out), 32'(i - 1));
      end
      chk("wrap_no_flags", 32'({ovf, udf}), 32'd0);

      // Random stream with a mid-stream reset
      do_reset("rst5");
      for (int i = 0; i < 200; i++) begin
         if (i == 100) do_reset("rst_mid");
         step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit reached");
   end

endmodule
